corr_frame_sequencer: RTL and testbench
=======================================

Name: corr_frame_sequencer

Overview:
- Upstream feeder for the ASCII-hex word transmitter on the correlator UART link.
- On a capture strobe, snapshots NUM_CHANNELS correlator accumulators, then presents them one word at a time on word_data/word_en.
- Advances on each completion edge of the transmitter's done flag.
- Sends one frame of words per capture; reports frame completion and captures dropped while busy.

Parameters:
- RESOLUTION, 32, bits per word; must be a multiple of 4.
- NUM_CHANNELS, 4, number of channels per frame, minimum 1.
- IDX_W, 4, index counter width; must satisfy 2^IDX_W > NUM_CHANNELS.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- capture  input  1  single-cycle request to snapshot ch_data and send a frame.
- ch_data  input  NUM_CHANNELS*RESOLUTION  flat accumulator bus; channel k at [k*RESOLUTION +: RESOLUTION].
- word_data  output  RESOLUTION  word presented to the transmitter.
- word_en  output  1  transmitter enable; high for the whole frame.
- word_done  input  1  transmitter done level; produced in a different timing domain.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse after the last word completes.
- dropped_cnt  output  8  saturating count of ignored captures.

Behaviour:
- Reset values (async, rst_n=0): word_data=0, word_en=0, busy=0, frame_done=0, dropped_cnt=0, state=IDLE, index=0, done sync flops=0.
- word_done passes through a 2-flop synchronizer plus a previous-value register.
  - done_rise is high for one cycle when the synced value goes 0->1.
  - Latency: 3 clk cycles from a word_done edge to done_rise.
- States: IDLE, SEND, FINISH.
- IDLE, capture=1:
  - Next cycle: snapshot ch_data into the internal array, index=0.
  - word_data = channel 0, word_en=1, busy=1, state=SEND.
- SEND:
  - word_data = snapshot[index], held stable until done_rise.
  - On done_rise with index < NUM_CHANNELS-1: index+1, word_data updates on the same edge, word_en stays 1.
  - On done_rise with index = NUM_CHANNELS-1: word_en=0, state=FINISH.
- FINISH (one cycle):
  - frame_done=1, busy=0 on exit, index=0, state=IDLE.
  - word_data holds the last word.
- Capture while not IDLE (SEND or FINISH):
  - Ignored.
  - dropped_cnt +1, saturating at 255.
  - Snapshot unaffected.
- Capture in the same cycle as the FINISH→IDLE transition: counted as dropped, not started.
- done_rise while in IDLE or FINISH: ignored.
- word_done already high when a frame starts: no rise is detected, so the block waits for a fresh 0->1 edge.
- NUM_CHANNELS=1: the first done_rise goes straight to FINISH.
- Reset mid-frame: immediate return to reset values; the snapshot is discarded, and its contents are don't-care.
- No arithmetic on the data path; words pass bit-exact.

Optional Feature:
- Macro: CORR_FRAME_HEADER_EN.
- Defined:
  - Each frame is prefixed with a header word = frame_cnt (RESOLUTION bits, reset 0).
  - Frame length is NUM_CHANNELS+1; index 0 is the header, index k+1 is channel k.
  - frame_cnt increments by 1 on each frame_done pulse and wraps modulo 2^RESOLUTION.
  - Requires 2^IDX_W > NUM_CHANNELS+1.
- Undefined:
  - No header and no frame_cnt register.
  - Frame is exactly NUM_CHANNELS words.

Test Plan:
- Reset then idle with word_done toggling → word_en=0, word_data=0, busy=0, dropped_cnt=0 throughout.
- ch_data = {32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001}, capture pulse, word_done 0->1 every 200 cycles → word_data sequence 1,2,3,4, each change 3 cycles after a done edge; word_en falls after the 4th edge; frame_done one pulse; busy low.
- Change ch_data to all 32'hFFFFFFFF one cycle after capture → transmitted words still equal the captured snapshot values.
- Pulse capture 3 times during a frame → dropped_cnt=3; a single frame is sent. Drive 300 extra captures → dropped_cnt saturates at 255.
- Assert rst_n=0 mid-frame at index 2 → outputs return to reset values on the same edge; a new capture restarts at channel 0.
- With CORR_FRAME_HEADER_EN defined: two back-to-back frames → first word 32'h00000000, second frame's first word 32'h00000001, 5 words per frame.

Source files
------------

// File: rtl/corr_frame_sequencer.sv
// Snapshots NUM_CHANNELS correlator accumulators on capture and streams them one word per transmitter completion.
// Optional build macro CORR_FRAME_HEADER_EN prefixes each frame with a running frame-count word.
module corr_frame_sequencer #(
  parameter int RESOLUTION   = 32,
  parameter int NUM_CHANNELS = 4,
  parameter int IDX_W        = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               capture,
  input  logic [NUM_CHANNELS*RESOLUTION-1:0] ch_data,
  output logic [RESOLUTION-1:0]              word_data,
  output logic                               word_en,
  input  logic                               word_done,
  output logic                               busy,
  output logic                               frame_done,
  output logic [7:0]                         dropped_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, FINISH} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [RESOLUTION-1:0] snap [NUM_CHANNELS];
  logic [IDX_W-1:0]      index;
  logic [IDX_W-1:0]      index_inc;
  logic                  done_s1;
  logic                  done_s2;
  logic                  done_prev;
  logic                  done_rise;
  logic [RESOLUTION-1:0] first_word;
  logic [RESOLUTION-1:0] next_word;
  logic                  load;
  logic                  advance;
  logic                  last_done;
  logic                  drop;
  logic                  at_last;

`ifdef CORR_FRAME_HEADER_EN
  localparam int HDR = 1;
  logic [RESOLUTION-1:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_cnt <= '0;
    else if (frame_done)
      frame_cnt <= frame_cnt + 1'b1;
  end

  assign first_word = frame_cnt;
`else
  localparam int HDR = 0;
  assign first_word = ch_data[RESOLUTION-1:0];
`endif

  localparam int               FRAME_LEN = NUM_CHANNELS + HDR;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);

  // word_done comes from another timing domain: two-flop sync, then edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_s1   <= 1'b0;
      done_s2   <= 1'b0;
      done_prev <= 1'b0;
    end else begin
      done_s1   <= word_done;
      done_s2   <= done_s1;
      done_prev <= done_s2;
    end
  end

  assign done_rise = done_s2 & ~done_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = SEND;
      SEND:    if (done_rise && at_last) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    at_last   = (index == LAST_IDX);
    load      = (state == IDLE) && capture;
    advance   = (state == SEND) && done_rise && !at_last;
    last_done = (state == SEND) && done_rise && at_last;
    drop      = capture && (state != IDLE);
  end

  assign index_inc = index + 1'b1;

  always_comb begin
    next_word = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (index_inc == IDX_W'(k + HDR))
        next_word = snap[k];
    end
  end

  // Snapshot contents are don't-care after reset, so no reset is needed here
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < NUM_CHANNELS; k++)
        snap[k] <= ch_data[k*RESOLUTION +: RESOLUTION];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index       <= '0;
      word_data   <= '0;
      word_en     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      dropped_cnt <= '0;
    end else begin
      frame_done <= last_done;
      if (load) begin
        index     <= '0;
        word_data <= first_word;
        word_en   <= 1'b1;
        busy      <= 1'b1;
      end else if (advance) begin
        index     <= index_inc;
        word_data <= next_word;
      end else if (last_done) begin
        word_en <= 1'b0;
      end else if (state == FINISH) begin
        busy  <= 1'b0;
        index <= '0;
      end
      if (drop && (dropped_cnt != 8'hFF))
        dropped_cnt <= dropped_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_corr_frame_sequencer.sv
// Randomized bench for corr_frame_sequencer: expected frames are built from the captured channel words.
module tb_corr_frame_sequencer;
  localparam int W = 32;
  localparam int N = 4;
`ifdef CORR_FRAME_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           capture = 1'b0;
  logic [N*W-1:0] ch_data = '0;
  logic [W-1:0]   word_data;
  logic           word_en;
  logic           word_done = 1'b0;
  logic           busy;
  logic           frame_done;
  logic [7:0]     dropped_cnt;

  int           vectors = 0;
  int           miscompares = 0;
  int           exp_dropped = 0;
  logic [W-1:0] exp_fcnt = '0;

  corr_frame_sequencer #(.RESOLUTION(W), .NUM_CHANNELS(N), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .capture(capture), .ch_data(ch_data),
    .word_data(word_data), .word_en(word_en), .word_done(word_done),
    .busy(busy), .frame_done(frame_done), .dropped_cnt(dropped_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [N*W-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Runs one frame: capture, then one word_done rise per expected word, checking each word and the 3-cycle latency
  task automatic drive_frame(input logic [N*W-1:0] data, input int gap, input int n_drop,
                             input bit corrupt, input bit done_high, input bit finish_cap);
    logic [W-1:0] exp_q[$];
    int           last;
    exp_q = {};
    if (HDR != 0) exp_q.push_back(exp_fcnt);
    for (int k = 0; k < N; k++) exp_q.push_back(data[k*W +: W]);
    last = exp_q.size() - 1;
    ch_data = data;
    if (done_high) begin
      word_done = 1'b1;
      step(5);
    end
    capture = 1'b1;
    step(1);
    capture = 1'b0;
    if (corrupt) ch_data = '1;
    if (done_high) begin
      step(10);
      vectors++;
      if (word_data !== exp_q[0] || word_en !== 1'b1) begin
        miscompares++;
        $display("FAIL done_high_hold: word_data=%h en=%b want %h en=1", word_data, word_en, exp_q[0]);
      end
      word_done = 1'b0;
      step(4);
    end
    for (int i = 0; i <= last; i++) begin
      vectors++;
      if (word_data !== exp_q[i] || word_en !== 1'b1 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL word%0d_present: data=%h en=%b busy=%b want %h en=1 busy=1", i, word_data, word_en, busy, exp_q[i]);
      end
      if (i == 0) begin
        for (int d = 0; d < n_drop; d++) begin
          capture = 1'b1;
          ch_data = rand_data();
          step(1);
          capture = 1'b0;
          step(1);
        end
        exp_dropped = (exp_dropped + n_drop > 255) ? 255 : exp_dropped + n_drop;
      end
      step(gap);
      word_done = 1'b1;
      step(2);
      vectors++;
      if (word_data !== exp_q[i] || word_en !== 1'b1) begin
        miscompares++;
        $display("FAIL word%0d_hold: data=%h en=%b want %h en=1", i, word_data, word_en, exp_q[i]);
      end
      step(1);
      if (i < last) begin
        vectors++;
        if (word_data !== exp_q[i+1] || word_en !== 1'b1 || frame_done !== 1'b0) begin
          miscompares++;
          $display("FAIL word%0d_advance: data=%h en=%b fd=%b want %h en=1 fd=0", i, word_data, word_en, frame_done, exp_q[i+1]);
        end
        word_done = 1'b0;
        step(4);
      end else begin
        vectors++;
        if (word_en !== 1'b0 || frame_done !== 1'b1 || busy !== 1'b1 || word_data !== exp_q[i]) begin
          miscompares++;
          $display("FAIL finish: en=%b fd=%b busy=%b data=%h want en=0 fd=1 busy=1 data=%h", word_en, frame_done, busy, word_data, exp_q[i]);
        end
        if (finish_cap) begin
          capture = 1'b1;
          exp_dropped = (exp_dropped >= 255) ? 255 : exp_dropped + 1;
        end
        step(1);
        capture = 1'b0;
        exp_fcnt = exp_fcnt + 1'b1;
        vectors++;
        if (word_en !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0 || word_data !== exp_q[i] || dropped_cnt !== 8'(exp_dropped)) begin
          miscompares++;
          $display("FAIL idle_after: en=%b fd=%b busy=%b data=%h drop=%0d want 0 0 0 %h %0d", word_en, frame_done, busy, word_data, dropped_cnt, exp_q[i], exp_dropped);
        end
        word_done = 1'b0;
        step(4);
        vectors++;
        if (busy !== 1'b0 || word_en !== 1'b0) begin
          miscompares++;
          $display("FAIL no_restart: busy=%b en=%b want 0 0", busy, word_en);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ch_data = rand_data();
    step(2);
    vectors++;
    if (word_data !== '0 || word_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || dropped_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset: data=%h en=%b busy=%b fd=%b drop=%0d want all zero", word_data, word_en, busy, frame_done, dropped_cnt);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      word_done = 1'($urandom);
      step(1);
      vectors++;
      if (word_data !== '0 || word_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || dropped_cnt !== 8'd0) begin
        miscompares++;
        $display("FAIL idle_toggle%0d: data=%h en=%b busy=%b fd=%b drop=%0d want all zero", c, word_data, word_en, busy, frame_done, dropped_cnt);
      end
    end
    word_done = 1'b0;
    step(4);
  endtask

  task automatic test_basic_frame();
    drive_frame({32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001}, 200, 0, 1'b0, 1'b0, 1'b0);
    drive_frame(rand_data(), $urandom_range(8, 1), 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_snapshot();
    drive_frame(rand_data(), $urandom_range(6, 1), 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_drops();
    drive_frame(rand_data(), 3, 3, 1'b0, 1'b0, 1'b0);
    drive_frame(rand_data(), 3, 300, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_done_high_at_start();
    drive_frame(rand_data(), 2, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    logic [N*W-1:0] data;
    logic [W-1:0]   exp_w;
    data = rand_data();
    ch_data = data;
    capture = 1'b1;
    step(1);
    capture = 1'b0;
    for (int r = 0; r < 2; r++) begin
      word_done = 1'b1;
      step(3);
      word_done = 1'b0;
      step(4);
    end
    exp_w = (HDR != 0) ? data[W +: W] : data[2*W +: W];
    vectors++;
    if (word_data !== exp_w || word_en !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_frame_index2: data=%h en=%b want %h en=1", word_data, word_en, exp_w);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (word_data !== '0 || word_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || dropped_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL mid_frame_reset: data=%h en=%b busy=%b fd=%b drop=%0d want all zero", word_data, word_en, busy, frame_done, dropped_cnt);
    end
    exp_dropped = 0;
    exp_fcnt = '0;
    step(1);
    rst_n = 1'b1;
    step(1);
    drive_frame(rand_data(), 2, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    exp_dropped = 0;
    exp_fcnt = '0;
    step(1);
    drive_frame(rand_data(), $urandom_range(5, 1), 0, 1'b0, 1'b0, 1'b1);
    drive_frame(rand_data(), $urandom_range(5, 1), 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_snapshot();
    test_drops();
    test_done_high_at_start();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
